// File: rtl/mpadder_pkg.sv
// mpadder_pkg: shared definitions for the mpadder control sequencer.
//   state_t    - sequencer states
//   sel_t      - in_a operand select codes driven on dp_sel
//   CHUNK_W    - width of the adder chunk index
//   IDLE_CHUNK - chunk code driven when no chunk pass is active. Bit 3 set
//                freezes the adder's chunk carry register.
package mpadder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD_B,
        ADD_M,
        SHIFT,
        RESOLVE,
        SUB,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_B    = 2'b01,
        SEL_M    = 2'b10
    } sel_t;

    localparam int                CHUNK_W    = 4;
    localparam logic [CHUNK_W-1:0] IDLE_CHUNK = 4'd8;

endpackage

// File: rtl/mpadder_seq_if.sv
// mpadder_seq_if: bundle between the Montgomery sequencer and its
// surroundings (start/done interface plus the adder control lines).
//   master modport : the sequencer (drives bit_idx, dp_*, busy, done, sub_err)
//   slave modport  : top level / datapath (drives start, a_bit, dp_czero,
//                    dp_sub_done)
// Parameter NBITS sets the bit_idx width ($clog2(NBITS)).
interface mpadder_seq_if #(
    parameter int NBITS = 512
);
    import mpadder_pkg::*;

    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic               start;
    logic               a_bit;
    logic               dp_czero;
    logic               dp_sub_done;
    logic [IDX_W-1:0]   bit_idx;
    logic               dp_enable_c;
    logic               dp_shift;
    logic               dp_subtract;
    logic [CHUNK_W-1:0] dp_chunk;
    logic [1:0]         dp_sel;
    logic               busy;
    logic               done;
    logic               sub_err;

    modport master (
        input  start, a_bit, dp_czero, dp_sub_done,
        output bit_idx, dp_enable_c, dp_shift, dp_subtract, dp_chunk, dp_sel,
               busy, done, sub_err
    );

    modport slave (
        output start, a_bit, dp_czero, dp_sub_done,
        input  bit_idx, dp_enable_c, dp_shift, dp_subtract, dp_chunk, dp_sel,
               busy, done, sub_err
    );

endinterface

// File: rtl/mpadder_chunk_cnt.sv
// mpadder_chunk_cnt: modulo-NCHUNK chunk counter shared by the resolve and
// subtract passes.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous clear to 0
//   enable     : advance; wraps to 0 after NCHUNK-1
//   count      : current chunk index
//   last       : count == NCHUNK-1
module mpadder_chunk_cnt #(
    parameter int NCHUNK = 5,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= last ? '0 : count_reg + 1'b1;
        end
    end

    assign last  = (count_reg == W'(NCHUNK - 1));
    assign count = count_reg;

endmodule

// File: rtl/mpadder_seq.sv
// mpadder_seq: control FSM that runs the 514-bit carry-save mpadder through
// one Montgomery multiply: per-bit ADD_B/ADD_M/SHIFT loop, one carry-resolve
// chunk pass, then up to MAX_SUB conditional-subtract chunk passes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mpadder_seq_if.master (start/done/busy/sub_err plus adder
//                controls dp_enable_c, dp_shift, dp_subtract, dp_chunk,
//                dp_sel and the loop index bit_idx)
// Optional build macro MPADDER_SEQ_SKIP_EN: zero multiplier bits skip the
// idle ADD_B cycle; a_bit must then present the bit for the upcoming index
// during IDLE (on start) and SHIFT.
module mpadder_seq
    import mpadder_pkg::*;
#(
    parameter int NBITS   = 512,
    parameter int NCHUNK  = 5,
    parameter int MAX_SUB = 3
) (
    input logic           clk,
    input logic           reset,
    mpadder_seq_if.master bus
);

    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SUB_W = (MAX_SUB > 1) ? $clog2(MAX_SUB) : 1;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   bit_idx_reg, bit_idx_next;
    logic [SUB_W-1:0]   sub_cnt_reg, sub_cnt_next;
    logic               sub_err_reg, sub_err_next;

    logic               cnt_clr, cnt_en, cnt_last;
    logic [CHUNK_W-1:0] cnt_val;

    logic               enable_c, shift, subtract, busy, done;
    logic [CHUNK_W-1:0] chunk;
    logic [1:0]         sel;
    logic               skip_zero;

`ifdef MPADDER_SEQ_SKIP_EN
    // A zero multiplier bit needs no B add, so go straight to ADD_M.
    assign skip_zero = ~bus.a_bit;
`else
    assign skip_zero = 1'b0;
`endif

    mpadder_chunk_cnt #(
        .NCHUNK (NCHUNK),
        .W      (CHUNK_W)
    ) u_chunk_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .count  (cnt_val),
        .last   (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_idx_reg <= '0;
            sub_cnt_reg <= '0;
            sub_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            sub_cnt_reg <= sub_cnt_next;
            sub_err_reg <= sub_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        sub_cnt_next = sub_cnt_reg;
        sub_err_next = sub_err_reg;
        enable_c     = 1'b0;
        shift        = 1'b0;
        subtract     = 1'b0;
        chunk        = IDLE_CHUNK;
        sel          = SEL_ZERO;
        busy         = 1'b1;
        done         = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                busy    = 1'b0;
                cnt_clr = 1'b1;
                if (bus.start) begin
                    bit_idx_next = '0;
                    sub_cnt_next = '0;
                    sub_err_next = 1'b0;
                    state_next   = skip_zero ? ADD_M : ADD_B;
                end
            end
            ADD_B: begin
                if (bus.a_bit) begin
                    enable_c = 1'b1;
                    sel      = SEL_B;
                end
                state_next = ADD_M;
            end
            ADD_M: begin
                // dp_czero already includes this bit's B add.
                if (bus.dp_czero) begin
                    enable_c = 1'b1;
                    sel      = SEL_M;
                end
                state_next = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                if (bit_idx_reg == IDX_W'(NBITS - 1)) begin
                    state_next = RESOLVE;
                end else begin
                    bit_idx_next = bit_idx_reg + 1'b1;
                    state_next   = skip_zero ? ADD_M : ADD_B;
                end
            end
            RESOLVE: begin
                chunk  = cnt_val;
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_next = SUB;
                end
            end
            SUB: begin
                subtract = 1'b1;
                chunk    = cnt_val;
                cnt_en   = 1'b1;
                // The adder's finished flag is only meaningful on the last chunk.
                if (cnt_last) begin
                    if (bus.dp_sub_done) begin
                        state_next = DONE;
                    end else if (sub_cnt_reg == SUB_W'(MAX_SUB - 1)) begin
                        sub_err_next = 1'b1;
                        state_next   = DONE;
                    end else begin
                        sub_cnt_next = sub_cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.bit_idx     = bit_idx_reg;
    assign bus.dp_enable_c = enable_c;
    assign bus.dp_shift    = shift;
    assign bus.dp_subtract = subtract;
    assign bus.dp_chunk    = chunk;
    assign bus.dp_sel      = sel;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.sub_err     = sub_err_reg;

endmodule

// File: tb/tb_mpadder_seq.sv
// tb_mpadder_seq: self-checking bench for mpadder_seq (NBITS=4).
// A per-operation model walks the multiply from its rules (per-bit
// B add / M add / shift, one resolve pass, subtract passes until the
// finished flag or the pass limit) and publishes the expected outputs for
// each cycle; a single negedge process compares the DUT against them.
// Inputs not consumed in a cycle are randomised.
module tb_mpadder_seq;
    import mpadder_pkg::*;

    localparam int NBITS   = 4;
    localparam int NCHUNK  = 5;
    localparam int MAX_SUB = 3;
`ifdef MPADDER_SEQ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mpadder_seq_if #(.NBITS(NBITS)) bus ();

    mpadder_seq #(
        .NBITS   (NBITS),
        .NCHUNK  (NCHUNK),
        .MAX_SUB (MAX_SUB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic        exp_valid = 1'b0;
    logic        exp_en, exp_shift, exp_sub, exp_busy, exp_done, exp_err;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_chunk;
    logic [1:0]  exp_idx;

    logic [1:0]  prev_idx = '0;
    logic        prev_err = 1'b0;
    int          op_num   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("dp_enable_c", 32'(bus.dp_enable_c), 32'(exp_en));
            chk("dp_sel",      32'(bus.dp_sel),      32'(exp_sel));
            chk("dp_shift",    32'(bus.dp_shift),    32'(exp_shift));
            chk("dp_subtract", 32'(bus.dp_subtract), 32'(exp_sub));
            chk("dp_chunk",    32'(bus.dp_chunk),    32'(exp_chunk));
            chk("busy",        32'(bus.busy),        32'(exp_busy));
            chk("done",        32'(bus.done),        32'(exp_done));
            chk("sub_err",     32'(bus.sub_err),     32'(exp_err));
            chk("bit_idx",     32'(bus.bit_idx),     32'(exp_idx));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic en, input logic [1:0] sel, input logic sh,
                           input logic sb, input logic [3:0] ch, input logic bz,
                           input logic dn, input logic er, input logic [1:0] ix);
        exp_en = en; exp_sel = sel; exp_shift = sh; exp_sub = sb; exp_chunk = ch;
        exp_busy = bz; exp_done = dn; exp_err = er; exp_idx = ix;
        exp_valid = 1'b1;
    endtask

    // Random values on inputs the current cycle does not consume.
    task automatic junk(input bit noise);
        bus.a_bit       = 1'($urandom_range(0, 1));
        bus.dp_czero    = 1'($urandom_range(0, 1));
        bus.dp_sub_done = 1'($urandom_range(0, 1));
        bus.start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // One full multiply. ok_pass: subtract pass (0-based) on which the adder
    // reports finished; >= MAX_SUB means never. reset_mid: pulse reset in the
    // first subtract pass at chunk 2. lat counts cycles from start to done.
    task automatic run_op(input logic [NBITS-1:0] mult, input logic [NBITS-1:0] cz,
                          input int ok_pass, input bit noise, input bit reset_mid,
                          input bit start_on_done, output int lat, output int loop_cyc);
        int  n;
        int  p;
        bit  fin;
        bit  err;
        n = 0; err = 1'b0; fin = 1'b0; lat = 0;
        op_num++;

        junk(1'b0);
        bus.start = 1'b1;
        bus.a_bit = mult[0];
        set_exp(0, SEL_ZERO, 0, 0, IDLE_CHUNK, 0, 0, prev_err, prev_idx);
        step();

        for (int b = 0; b < NBITS; b++) begin
            if (!(SKIP && !mult[b])) begin
                junk(noise);
                bus.a_bit = mult[b];
                set_exp(mult[b], mult[b] ? SEL_B : SEL_ZERO, 0, 0, IDLE_CHUNK, 1, 0, 0, 2'(b));
                step(); n++;
            end
            junk(noise);
            bus.dp_czero = cz[b];
            set_exp(cz[b], cz[b] ? SEL_M : SEL_ZERO, 0, 0, IDLE_CHUNK, 1, 0, 0, 2'(b));
            step(); n++;
            junk(noise);
            if (b < NBITS - 1) bus.a_bit = mult[b+1];
            set_exp(0, SEL_ZERO, 1, 0, IDLE_CHUNK, 1, 0, 0, 2'(b));
            step(); n++;
        end
        loop_cyc = n;

        for (int c = 0; c < NCHUNK; c++) begin
            junk(noise);
            set_exp(0, SEL_ZERO, 0, 0, 4'(c), 1, 0, 0, 2'(NBITS - 1));
            step(); n++;
        end

        p = 0;
        while (!fin) begin
            for (int c = 0; c < NCHUNK; c++) begin
                junk(noise);
                if (c == NCHUNK - 1) bus.dp_sub_done = (p == ok_pass);
                set_exp(0, SEL_ZERO, 0, 1, 4'(c), 1, 0, 0, 2'(NBITS - 1));
                if (reset_mid && p == 0 && c == 2) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    junk(1'b0);
                    set_exp(0, SEL_ZERO, 0, 0, IDLE_CHUNK, 0, 0, 0, 2'd0);
                    step();
                    prev_idx = '0;
                    prev_err = 1'b0;
                    $display("op %0d mult=%b cz=%b aborted by reset in subtract chunk 2",
                             op_num, mult, cz);
                    return;
                end
                step(); n++;
            end
            if (p == ok_pass) fin = 1'b1;
            else if (p == MAX_SUB - 1) begin err = 1'b1; fin = 1'b1; end
            else p++;
        end

        junk(1'b0);
        bus.start = start_on_done;
        set_exp(0, SEL_ZERO, 0, 0, IDLE_CHUNK, 1, 1, err, 2'(NBITS - 1));
        step(); n++;
        lat = n;

        junk(1'b0);
        set_exp(0, SEL_ZERO, 0, 0, IDLE_CHUNK, 0, 0, err, 2'(NBITS - 1));
        step();
        prev_idx = 2'(NBITS - 1);
        prev_err = err;
        $display("op %0d mult=%b cz=%b sub_passes=%0d sub_err=%0b loop=%0d latency=%0d",
                 op_num, mult, cz, p + 1, err, loop_cyc, lat);
    endtask

    initial begin
        int lat;
        int loop_cyc;
        reset = 1'b1;
        bus.start = 1'b0; bus.a_bit = 1'b0; bus.dp_czero = 1'b0; bus.dp_sub_done = 1'b0;
        step();
        step();
        reset = 1'b0;
        set_exp(0, SEL_ZERO, 0, 0, IDLE_CHUNK, 0, 0, 0, 2'd0);
        step();

        // All ones, no M adds, finished on first subtract pass.
        run_op(4'b1111, 4'b0000, 0, 1'b0, 1'b0, 1'b0, lat, loop_cyc);
        chk("latency_basic", 32'(lat), 32'd23);

        // Exactly one M add, in bit 2.
        run_op(4'b1011, 4'b0100, 0, 1'b1, 1'b0, 1'b0, lat, loop_cyc);
        chk("latency_madd", 32'(lat), SKIP ? 32'd22 : 32'd23);

        // Finished on the third subtract pass.
        run_op(4'b1111, 4'b0000, 2, 1'b1, 1'b0, 1'b0, lat, loop_cyc);
        chk("latency_3pass", 32'(lat), 32'd33);

        // Never finished: error after MAX_SUB passes; start during DONE ignored.
        run_op(4'b1111, 4'b1001, 3, 1'b1, 1'b0, 1'b1, lat, loop_cyc);
        chk("latency_err", 32'(lat), 32'd33);
        chk("err_flag_held", 32'(prev_err), 32'd1);

        // Next start clears sub_err.
        run_op(4'b0110, 4'b0011, 1, 1'b1, 1'b0, 1'b0, lat, loop_cyc);

        // Reset in the middle of a subtract pass, then a clean operation.
        run_op(4'b1101, 4'b0010, 0, 1'b0, 1'b1, 1'b0, lat, loop_cyc);
        run_op(4'b1111, 4'b0000, 0, 1'b0, 1'b0, 1'b0, lat, loop_cyc);
        chk("latency_after_reset", 32'(lat), 32'd23);

        // Alternating multiplier bits.
        run_op(4'b0101, 4'b0000, 0, 1'b1, 1'b0, 1'b0, lat, loop_cyc);
        chk("loop_alt", 32'(loop_cyc), SKIP ? 32'd10 : 32'd12);

        for (int i = 0; i < 20; i++) begin
            run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                   1'b1, 1'b0, 1'($urandom_range(0, 1)), lat, loop_cyc);
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
